// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch squashes, data-memory
// wait freezes with a timeout that parks the pipe in a sticky error state.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  IF_IDRs,
  input  logic [3:0]  IF_IDRt,
  input  logic [3:0]  ID_EXRd,
  input  logic        ID_EXMemRead,
  input  logic        EX_MEMMemRead,
  input  logic        EX_MEMMemWrite,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        pc_en,
  output logic        IF_ID_en,
  output logic        ID_EX_en,
  output logic        EX_MEM_en,
  output logic        IF_ID_flush,
  output logic        ID_EX_bubble,
  output logic        mem_req,
  output logic        mem_err,
  output logic [15:0] stall_count
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned STALL_W = 16;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    ERROR   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic                 mem_err_q, mem_err_d;
  logic [STALL_W-1:0]   stall_count_q, stall_count_d;

  logic acc, mem_busy, load_use;

  assign acc      = EX_MEMMemRead | EX_MEMMemWrite;
  assign mem_busy = acc & ~mem_ready;
  assign load_use = ID_EXMemRead & (ID_EXRd != 4'd0) &
                    ((ID_EXRd == IF_IDRs) | (ID_EXRd == IF_IDRt));

  // Next-state and zero-latency pipeline control
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_err_d     = mem_err_q;
    stall_count_d = stall_count_q;
    pc_en         = 1'b0;
    IF_ID_en      = 1'b0;
    ID_EX_en      = 1'b0;
    EX_MEM_en     = 1'b0;
    IF_ID_flush   = 1'b0;
    ID_EX_bubble  = 1'b0;
    mem_req       = 1'b0;

    case (state_q)
      RUN, MEMWAIT: begin
        mem_req = acc;
        if (mem_busy) begin
          if (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
            state_d   = ERROR;
            mem_err_d = 1'b1;
          end else begin
            state_d    = MEMWAIT;
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end else begin
          state_d    = RUN;
          wait_cnt_d = '0;
          if (branch_taken) begin
            pc_en        = 1'b1;
            IF_ID_en     = 1'b1;
            ID_EX_en     = 1'b1;
            EX_MEM_en    = 1'b1;
            IF_ID_flush  = 1'b1;
            ID_EX_bubble = 1'b1;
          end else if (load_use) begin
            ID_EX_en     = 1'b1;
            ID_EX_bubble = 1'b1;
            EX_MEM_en    = 1'b1;
          end else begin
            pc_en     = 1'b1;
            IF_ID_en  = 1'b1;
            ID_EX_en  = 1'b1;
            EX_MEM_en = 1'b1;
          end
        end
        if (!pc_en && (stall_count_q != '1)) begin
          stall_count_d = stall_count_q + STALL_W'(1);
        end
      end
      default: begin
        state_d = ERROR;
      end
    endcase

    // Controls are forced idle for as long as reset is held
    if (!rst) begin
      pc_en        = 1'b0;
      IF_ID_en     = 1'b0;
      ID_EX_en     = 1'b0;
      EX_MEM_en    = 1'b0;
      IF_ID_flush  = 1'b0;
      ID_EX_bubble = 1'b0;
      mem_req      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_err_q     <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_err_q     <= mem_err_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign mem_err     = mem_err_q;
  assign stall_count = stall_count_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16, the number of consecutive data-memory wait cycles tolerated before error; legal range 2..255.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; asynchronous assertion, active-low (0 = reset).
REQ-004 IF_IDRs  input  4  source register 1 of the instruction held in IF/ID.
REQ-005 IF_IDRt  input  4  source register 2 of the instruction held in IF/ID.
REQ-006 ID_EXRd  input  4  destination register of the instruction held in ID/EX.
REQ-007 ID_EXMemRead  input  1  the ID/EX instruction is a load.
REQ-008 EX_MEMMemRead, EX_MEMMemWrite  input  1 each  the EX/MEM instruction accesses data memory.
REQ-009 mem_ready  input  1  data memory completes the current access this cycle.
REQ-010 branch_taken  input  1  the EX-stage branch resolves taken this cycle.
REQ-011 pc_en, IF_ID_en, ID_EX_en, EX_MEM_en  output  1 each  load enables for the PC and the pipeline registers.
REQ-012 IF_ID_flush, ID_EX_bubble  output  1 each  force the named register to NOP or zero-control on its next load.
REQ-013 mem_req  output  1  data-memory access request.
REQ-014 mem_err  output  1  sticky memory-timeout error.
REQ-015 stall_count  output  16  saturating count of stalled cycles.

Function
REQ-016 Definitions: acc = EX_MEMMemRead|EX_MEMMemWrite; mem_busy = acc & ~mem_ready; load_use = ID_EXMemRead & (ID_EXRd!=0) & (ID_EXRd==IF_IDRs | ID_EXRd==IF_IDRt).
REQ-017 FSM states: RUN, MEMWAIT, ERROR. There is an 8-bit wait counter wait_cnt.
REQ-018 Enable, flush, bubble and mem_req outputs shall be combinational from the state and the current inputs, with zero-cycle latency.
REQ-019 Priority in RUN/MEMWAIT: mem_busy, then branch_taken, then load_use, then normal operation.
REQ-020 mem_busy: all four enables 0, IF_ID_flush=0, ID_EX_bubble=0; the whole pipe freezes.
REQ-021 branch_taken without mem_busy: all enables 1, IF_ID_flush=1, ID_EX_bubble=1; the two younger instructions are squashed.
REQ-022 load_use only: pc_en=0, IF_ID_en=0, ID_EX_en=1, ID_EX_bubble=1, EX_MEM_en=1; this gives exactly one bubble per hazard.
REQ-023 Normal operation: all enables 1, flush and bubble 0.
REQ-024 mem_req = acc whenever state != ERROR; 0 in ERROR.
REQ-025 RUN->MEMWAIT when mem_busy, with wait_cnt<=1. MEMWAIT holds while mem_busy, with wait_cnt<=wait_cnt+1.
REQ-026 MEMWAIT->RUN when ~mem_busy, with wait_cnt<=0.
REQ-027 Any state with mem_busy and wait_cnt==MEM_TIMEOUT-1 moves to ERROR, so mem_err rises the cycle after the MEM_TIMEOUT-th consecutive busy cycle.
REQ-028 ERROR: all enables 0, flush and bubble 0, mem_err=1; it is left only by reset, and inputs are ignored.
REQ-029 stall_count increments on every cycle in RUN/MEMWAIT where pc_en==0, and holds at 16'hFFFF.
REQ-030 If mem_ready and branch_taken are high in the same cycle as a load_use, branch wins: no stall, flush applied.
REQ-031 A load_use with ID_EXRd==0 shall not stall.

Reset
REQ-032 While rst==0: state=RUN, wait_cnt=0, mem_err=0, stall_count=0, all enables 0, flush/bubble 0, mem_req=0.
REQ-033 Reset asserted mid-MEMWAIT or in ERROR shall return the block to RUN immediately and asynchronously.
REQ-034 The first cycle after rst rises is normal RUN operation.

Verification
REQ-035 Load-use: ID_EXMemRead=1, ID_EXRd=5, IF_IDRt=5 for one cycle -> pc_en=0, IF_ID_en=0, ID_EX_bubble=1 in that cycle only; stall_count=1.
REQ-036 Zero register: same stimulus with ID_EXRd=0 -> no stall; stall_count stays 0.
REQ-037 Branch beats hazard: branch_taken=1 together with the load_use stimulus -> all enables 1, IF_ID_flush=1, ID_EX_bubble=1.
REQ-038 Memory wait: EX_MEMMemRead=1 and mem_ready=0 for 3 cycles then 1 -> 3 frozen cycles, mem_req=1 throughout, state RUN after; stall_count=3.
REQ-039 Timeout: MEM_TIMEOUT=4 with mem_ready held 0 -> mem_err=1 from cycle 5 onward; enables stay 0 after mem_ready later rises; rst pulse clears mem_err.
REQ-040 Saturation: 70000 load-use cycles -> stall_count=16'hFFFF and no wrap.
